bram_read_streamer: RTL

Sequences reads out of a one-cycle-latency simple dual-port block RAM and presents the words as a valid/ready stream with a `last` marker. It drives the RAM read port (`raddr`) and consumes its registered `dout`, hiding the read latency behind a 3-entry output buffer. With `out_ready` held high it sustains one word per cycle. It is used to dump or replay memory contents, such as instruction or register images, toward a downstream consumer.

---
 rtl/bram_read_streamer_pkg.sv | 15 +
 rtl/bram_read_streamer_if.sv | 12 +
 rtl/bram_stream_fifo.sv | 64 ++++++
 rtl/bram_read_streamer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/bram_read_streamer_pkg.sv
// Shared types and sizing for the block-RAM read streamer.
package bram_read_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned FIFO_DEPTH        = 3;
  localparam int unsigned STALL_COUNT_WIDTH = 32;
  localparam int unsigned OCC_WIDTH         = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_read_streamer_if.sv
// Valid/ready output stream carrying RAM words plus an end-of-burst marker.
interface bram_read_streamer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (output out_valid, output out_data, output out_last, input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_last, output out_ready);
endinterface

// File: rtl/bram_stream_fifo.sv
// Small first-word-fall-through FIFO built as a shift register so the head word is a flop.
module bram_stream_fifo
  import bram_read_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q;
  logic [FIFO_DEPTH-1:0] vld_d;
  logic                  placed;

  // Shift out on pop first, then drop the new word into the lowest free slot.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    placed = 1'b0;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
        vld_d[i]  = vld_q[i+1];
      end
      vld_d[FIFO_DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (!vld_d[i] && !placed) begin
          data_d[i] = push_data;
          vld_d[i]  = 1'b1;
          placed    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) occupancy = occupancy + OCC_WIDTH'(vld_q[i]);
  end

  assign head_valid = vld_q[0];
  assign head_data  = data_q[0];

endmodule

// File: rtl/bram_read_streamer.sv
// Streams a burst of words out of a one-cycle-latency block RAM as valid/ready beats.
// Optional BRAM_READ_STREAMER_STALL_COUNT_EN adds a saturating backpressure cycle counter.
module bram_read_streamer
  import bram_read_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 11,
  parameter int unsigned COUNT_WIDTH   = ADDRESS_WIDTH + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]   count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0]    dout,
  bram_read_streamer_if.master     stream
`ifdef BRAM_READ_STREAMER_STALL_COUNT_EN
  ,
  output logic [STALL_COUNT_WIDTH-1:0] stall_cycles
`endif
);

  localparam int unsigned SUM_WIDTH = OCC_WIDTH + 1;

  state_t                 state_q, state_d;
  logic                   accept;
  logic                   issue;
  logic                   handshake;
  logic                   pending_q;
  logic                   rem_one_q;
  logic [COUNT_WIDTH-1:0] issue_rem_q;
  logic [COUNT_WIDTH-1:0] out_rem_q;
  logic                   head_valid;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [OCC_WIDTH-1:0]   occupancy;

  assign accept    = (state_q == IDLE) && start;
  assign handshake = head_valid && stream.out_ready;
  // Reads in flight are reserved buffer slots, so issue never looks at out_ready.
  assign issue     = (state_q == RUN) &&
                     ((SUM_WIDTH'(occupancy) + SUM_WIDTH'(pending_q)) < SUM_WIDTH'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (count == '0) ? DONE : RUN;
      RUN:     if (issue && issue_rem_q == COUNT_WIDTH'(1)) state_d = DRAIN;
      DRAIN:   if (handshake && out_rem_q == COUNT_WIDTH'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN) || (state_d == DRAIN);
      done    <= (state_d == DONE);
    end
  end

  // Address and the two remaining-word counters; rem_one_q flags the final head word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raddr       <= '0;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      rem_one_q   <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      pending_q <= issue;
      if (accept) begin
        raddr       <= base_addr;
        issue_rem_q <= count;
        out_rem_q   <= count;
        rem_one_q   <= (count == COUNT_WIDTH'(1));
      end else begin
        if (issue) begin
          raddr       <= raddr + ADDRESS_WIDTH'(1);
          issue_rem_q <= issue_rem_q - COUNT_WIDTH'(1);
        end
        if (handshake) begin
          out_rem_q <= out_rem_q - COUNT_WIDTH'(1);
          rem_one_q <= (out_rem_q == COUNT_WIDTH'(2));
        end
      end
    end
  end

  bram_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (pending_q),
    .push_data  (dout),
    .pop        (handshake),
    .head_valid (head_valid),
    .head_data  (head_data),
    .occupancy  (occupancy)
  );

  assign stream.out_valid = head_valid;
  assign stream.out_data  = head_data;
  assign stream.out_last  = head_valid && rem_one_q;

`ifdef BRAM_READ_STREAMER_STALL_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (head_valid && !stream.out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_COUNT_WIDTH'(1);
    end
  end
`endif

endmodule
